// File: rtl/audio_player.sv
// Square-wave tone generator driven by the control unit's audio strobes; returns a one-cycle continue pulse per note.
// Define AUDIO_GAP_EN to insert GAP_TICKS silent ticks after every note.
module audio_player #(
    parameter int DW        = 16,
    parameter int TICK_DIV  = 12000,
    parameter int GAP_TICKS = 10
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [DW-1:0] din_i,
    input  logic          audioreg_i,
    input  logic          audioact_i,
    input  logic          s_cont_i,
    output logic          speaker_o,
    output logic          playing_o,
    output logic          continue_o
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    if (TICK_DIV < 1 || GAP_TICKS < 0) begin : g_bad_params
        $error("audio_player: TICK_DIV must be >= 1 and GAP_TICKS >= 0");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
`ifdef AUDIO_GAP_EN
        GAP  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    state_t        state_q;
    logic [DW-1:0] hp_q;
    logic [DW-1:0] dur_q;
    logic [DW-1:0] tone_cnt_q;
    logic [DW-1:0] dur_cnt_q;
    logic [TW-1:0] tick_cnt_q;
`ifdef AUDIO_GAP_EN
    logic [DW-1:0] gap_cnt_q;
`endif
    logic          speaker_q;
    logic          playing_q;
    logic          continue_q;

    logic set_hp;
    logic play_cmd;
    logic tick_wrap;

    assign set_hp    = audioact_i & s_cont_i;
    assign play_cmd  = audioact_i & ~s_cont_i;
    assign tick_wrap = (tick_cnt_q == TICK_LAST);

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            hp_q       <= '0;
            dur_q      <= '0;
            tone_cnt_q <= '0;
            dur_cnt_q  <= '0;
            tick_cnt_q <= '0;
`ifdef AUDIO_GAP_EN
            gap_cnt_q  <= '0;
`endif
            speaker_q  <= 1'b0;
            playing_q  <= 1'b0;
            continue_q <= 1'b0;
        end else begin
            if (audioreg_i) dur_q <= din_i;
            if (set_hp)     hp_q  <= din_i;

            case (state_q)
                IDLE: begin
                    speaker_q  <= 1'b0;
                    playing_q  <= 1'b0;
                    continue_q <= 1'b0;
                    if (play_cmd) begin
                        dur_cnt_q  <= dur_q;
                        tick_cnt_q <= '0;
                        tone_cnt_q <= '0;
                        if (dur_q != '0) begin
                            state_q   <= PLAY;
                            playing_q <= 1'b1;
                        end else begin
                            state_q    <= DONE;
                            continue_q <= 1'b1;
                        end
                    end
                end

                PLAY: begin
                    tick_cnt_q <= tick_wrap ? '0 : tick_cnt_q + 1'b1;

                    // A new half-period restarts the current half-cycle without touching the level.
                    if (set_hp) begin
                        tone_cnt_q <= '0;
                    end else if (hp_q == '0) begin
                        tone_cnt_q <= '0;
                        speaker_q  <= 1'b0;
                    end else if (tone_cnt_q == hp_q - 1'b1) begin
                        tone_cnt_q <= '0;
                        speaker_q  <= ~speaker_q;
                    end else begin
                        tone_cnt_q <= tone_cnt_q + 1'b1;
                    end

                    if (tick_wrap) begin
                        if (dur_cnt_q == DW'(1)) begin
                            dur_cnt_q  <= '0;
                            tone_cnt_q <= '0;
                            speaker_q  <= 1'b0;
`ifdef AUDIO_GAP_EN
                            state_q    <= GAP;
                            gap_cnt_q  <= DW'(GAP_TICKS);
`else
                            state_q    <= DONE;
                            playing_q  <= 1'b0;
                            continue_q <= 1'b1;
`endif
                        end else begin
                            dur_cnt_q <= dur_cnt_q - 1'b1;
                        end
                    end
                end

`ifdef AUDIO_GAP_EN
                GAP: begin
                    speaker_q  <= 1'b0;
                    tick_cnt_q <= tick_wrap ? '0 : tick_cnt_q + 1'b1;
                    // A zero-length gap still costs the single cycle spent in this state.
                    if (gap_cnt_q == '0 || (tick_wrap && gap_cnt_q == DW'(1))) begin
                        state_q    <= DONE;
                        gap_cnt_q  <= '0;
                        tick_cnt_q <= '0;
                        playing_q  <= 1'b0;
                        continue_q <= 1'b1;
                    end else if (tick_wrap) begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
`endif

                DONE: begin
                    // Any audioact seen here belongs to the retiring instruction.
                    continue_q <= 1'b0;
                    playing_q  <= 1'b0;
                    speaker_q  <= 1'b0;
                    state_q    <= IDLE;
                end

                default: begin
                    state_q    <= IDLE;
                    speaker_q  <= 1'b0;
                    playing_q  <= 1'b0;
                    continue_q <= 1'b0;
                end
            endcase
        end
    end

    assign speaker_o  = speaker_q;
    assign playing_o  = playing_q;
    assign continue_o = continue_q;

endmodule

// File: doc/audio_player.md
# audio_player

Tone-generation stage driven by the control unit's audio instruction strobes (`audioreg`, `audioact`, `s_cont`). It holds a note duration and a tone half-period loaded from the register-file data bus. On a play command it drives a square wave on `speaker` for the stored duration, then returns a one-cycle `continue` pulse. The control unit stalls the PC on the play instruction until that pulse arrives.

## Interface
- `DW`, 16: width of `din`, the half-period register, and the duration register.
- `TICK_DIV`, 12000: clock cycles per duration tick (1 ms at 12 MHz); must be ≥ 1.
- `GAP_TICKS`, 10: silent ticks inserted after each note; used only when `AUDIO_GAP_EN` is defined.

- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `din` in DW: operand from the register-file read port.
- `audioreg` in 1: load `din` into the duration register.
- `audioact` in 1: audio command active.
- `s_cont` in 1: qualifies `audioact`. When `s_cont`=1 the command is "set frequency"; when `s_cont`=0 it is "play".
- `speaker` out 1: square-wave output.
- `playing` out 1: high while a note is in progress.
- `continue` out 1: one-cycle note-complete pulse to the control unit.

## Operation
- Registers: `hp` (half-period, in cycles), `dur` (duration, in ticks), `tone_cnt`, `tick_cnt`, `dur_cnt`, state.
- Register loads happen in every state:
  - `audioreg`=1: `dur` ← `din`.
  - `audioact`=1 and `s_cont`=1: `hp` ← `din`.
  - If both fire in the same cycle, both loads occur.
- States: IDLE, PLAY, GAP (only with `AUDIO_GAP_EN`), DONE.
- IDLE:
  - `audioact`=1 and `s_cont`=0 (play command): load `dur_cnt` ← `dur`, clear `tick_cnt`, `tone_cnt`, and `speaker`.
  - Go to PLAY if `dur` ≠ 0; go to DONE if `dur` = 0.
- PLAY:
  - `tick_cnt` counts 0..TICK_DIV−1 and wraps; the wrap is the tick.
  - On each tick `dur_cnt` decrements.
  - A tick with `dur_cnt`=1 leaves PLAY for GAP or DONE. PLAY therefore lasts exactly `dur`×TICK_DIV cycles.
- Tone generation in PLAY:
  - `tone_cnt` counts 0..`hp`−1; on reaching `hp`−1 it toggles `speaker` and returns to 0.
  - Waveform period is 2×`hp` cycles.
  - `hp`=0 is a rest: `speaker` stays 0 while the duration still elapses.
- Loads during PLAY:
  - A `dur` load does not affect `dur_cnt`; it applies to the next note.
  - An `hp` load takes effect immediately and clears `tone_cnt`.
- DONE:
  - `continue`=1 for exactly one cycle, then go to IDLE unconditionally.
  - `audioact` seen in DONE is ignored. It belongs to the instruction being retired, because the PC advances on this edge.
- Outputs:
  - `speaker` is forced to 0 outside PLAY.
  - `playing` = 1 in PLAY and GAP.
- Width rules: all counters are DW bits except `tick_cnt`, which is ⌈log2(TICK_DIV)⌉ bits (minimum 1). No wraparound is possible in `dur_cnt`, since it is never decremented at 0.

## Timing
- Reset values (`reset`=0 at a rising edge): state=IDLE, `hp`=0, `dur`=0, all counters 0, `speaker`=0, `playing`=0, `continue`=0.
- Reset mid-note aborts the note immediately and emits no `continue`.
- Play latency, where the play command is sampled in IDLE at edge N:
  - `playing`=1 from N+1.
  - Last PLAY cycle is N+`dur`×TICK_DIV.
  - Without gap, `continue`=1 during cycle N+`dur`×TICK_DIV+1.
- Zero duration: `continue`=1 during cycle N+1.
- First `speaker` rise occurs `hp` cycles after PLAY entry.
- Back-to-back play instructions (`audioact` held high across DONE) start the next note in the IDLE cycle after DONE, with one dead cycle between notes.
- All outputs are registered. `continue` has no combinational path from inputs.

## Configuration
- `AUDIO_GAP_EN` defined:
  - PLAY exits to GAP.
  - GAP holds `speaker`=0 and `playing`=1 for GAP_TICKS×TICK_DIV cycles, then goes to DONE.
  - GAP_TICKS=0 passes through GAP in one cycle.
  - The `dur`=0 path skips GAP.
- `AUDIO_GAP_EN` undefined: the GAP state and its counter are absent, and PLAY goes directly to DONE.

## Test plan
All scenarios use TICK_DIV=4, DW=16.
- **Reset:** `reset`=0 for 2 cycles → all outputs 0; first play has `hp`=0 and `dur`=0, so `continue` arrives 1 cycle after the command.
- **Basic note:** load `hp`=3, `dur`=2; hold `audioact`=1, `s_cont`=0 →
  - `playing` high for 8 cycles.
  - `speaker` toggles every 3 cycles (first rise 3 cycles after entry).
  - `continue` pulse is exactly 1 cycle, 9 cycles after the command edge.
- **Rest:** `hp`=0, `dur`=1 → `speaker` stays 0, `playing` high for 4 cycles, then `continue`.
- **Back-to-back:** keep `audioact` high through two play instructions with `dur`=1 → two `continue` pulses 6 cycles apart, one IDLE cycle between notes.
- **Reset mid-note:** `dur`=5; pull `reset` low at PLAY cycle 7 → next cycle all outputs 0, state IDLE, no `continue`.
- **Gap (`AUDIO_GAP_EN`, GAP_TICKS=2):** `dur`=1 → 4 PLAY cycles, 8 silent GAP cycles with `playing`=1, then `continue`.
